// File: rtl/sdp_erdma_rd_cdt_gate.sv
// -----------------------------------------------------------------------------
// sdp_erdma_rd_cdt_gate
//
// Credit gate between the SDP ERDMA read-request output and the MCIF read
// request port. A request is admitted only when the read-latency FIFO has room
// for its whole response (size counted in 32B atoms). Credits are consumed on
// admission and returned one atom at a time by cdt_lat_fifo_pop. Admitted
// requests pass through a one-entry output pipe register.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   in_req_valid / in_req_ready      : ingress handshake
//   in_req_pd[78:0]                  : [63:0] address, [78:64] atoms minus 1
//   out_req_valid / out_req_ready    : MCIF handshake
//   out_req_pd[78:0]                 : registered copy of the admitted pd
//   cdt_lat_fifo_pop                 : one-atom credit return pulse
//   op_load                          : layer start, clears stall_cnt
//   perf_en                          : enables stall counting
//   stall_cnt[31:0]                  : saturating count of stalled cycles
//   credit_cnt[CW-1:0]               : current free credits
//   cdt_err                          : sticky credit overflow / oversize flag
// -----------------------------------------------------------------------------
module sdp_erdma_rd_cdt_gate #(
  parameter int LAT_FIFO_DEPTH = 160,
  parameter int CW             = 9     // 2**CW > LAT_FIFO_DEPTH, CW <= 16
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          in_req_valid,
  output logic          in_req_ready,
  input  logic [78:0]   in_req_pd,
  output logic          out_req_valid,
  input  logic          out_req_ready,
  output logic [78:0]   out_req_pd,
  input  logic          cdt_lat_fifo_pop,
  input  logic          op_load,
  input  logic          perf_en,
  output logic [31:0]   stall_cnt,
  output logic [CW-1:0] credit_cnt,
  output logic          cdt_err
);

  localparam logic [15:0]   LP_DEPTH_W  = 16'(LAT_FIFO_DEPTH);
  localparam logic [CW-1:0] LP_DEPTH_CW = CW'(LAT_FIFO_DEPTH);
  localparam logic [31:0]   LP_STALL_MAX = 32'hFFFF_FFFF;

  logic          r_out_valid;
  logic [78:0]   r_out_pd;
  logic [CW-1:0] r_credit;
  logic [31:0]   r_stall;
  logic          r_err;

  logic [15:0]   w_need;
  logic [15:0]   w_credit_ext;
  logic          w_eligible;
  logic          w_pipe_free;
  logic          w_accept;
  logic          w_oversize;
  logic [15:0]   w_credit_sum;
  logic          w_credit_ovf;
  logic [CW-1:0] w_credit_next;
  logic          w_stall_inc;

  // Request size in atoms; 16 bits so that size 0x7FFF + 1 does not wrap.
  assign w_need       = {1'b0, in_req_pd[78:64]} + 16'd1;
  assign w_credit_ext = 16'(r_credit);
  assign w_eligible   = (w_need <= w_credit_ext);
  // Pipe can take a new entry when empty or when its entry leaves this cycle.
  assign w_pipe_free  = ~r_out_valid | out_req_ready;
  assign in_req_ready = w_eligible & w_pipe_free;
  assign w_accept     = in_req_valid & in_req_ready;
  // A request larger than the whole FIFO can never be admitted.
  assign w_oversize   = in_req_valid & (w_need > LP_DEPTH_W);
  assign w_stall_inc  = perf_en & in_req_valid & ~in_req_ready;

  // Next credit value: consume on accept, return on pop, saturate at depth.
  // Accept implies need <= credit, so the subtraction never underflows.
  always_comb begin
    w_credit_sum = w_credit_ext;
    if (w_accept) begin
      w_credit_sum = w_credit_sum - w_need;
    end else begin
      w_credit_sum = w_credit_sum;
    end
    if (cdt_lat_fifo_pop) begin
      w_credit_sum = w_credit_sum + 16'd1;
    end else begin
      w_credit_sum = w_credit_sum;
    end
    w_credit_ovf = (w_credit_sum > LP_DEPTH_W);
    if (w_credit_ovf) begin
      w_credit_next = LP_DEPTH_CW;
    end else begin
      w_credit_next = CW'(w_credit_sum);
    end
  end

  // One-entry output pipe register; valid bit is the EMPTY/FULL state.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_out_valid <= 1'b0;
      r_out_pd    <= 79'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pd    <= in_req_pd;
    end else if (out_req_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Free-credit counter.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_credit <= LP_DEPTH_CW;
    end else begin
      r_credit <= w_credit_next;
    end
  end

  // Sticky error: credit overflow or an oversize request seen.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_err <= 1'b0;
    end else if (w_credit_ovf | w_oversize) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  // Stall counter; op_load wins over an increment in the same cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_stall <= 32'd0;
    end else if (op_load) begin
      r_stall <= 32'd0;
    end else if (w_stall_inc && (r_stall != LP_STALL_MAX)) begin
      r_stall <= r_stall + 32'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign out_req_valid = r_out_valid;
  assign out_req_pd    = r_out_pd;
  assign credit_cnt    = r_credit;
  assign stall_cnt     = r_stall;
  assign cdt_err       = r_err;

endmodule

// File: doc/sdp_erdma_rd_cdt_gate.md
Name: sdp_erdma_rd_cdt_gate

Overview:
- Sits between the SDP ERDMA read-request output and the MCIF read-request port.
- Admits each request only when enough credits remain in the MCIF read-latency FIFO to hold its full response. Request size is in 32B atoms.
- Credits are consumed on request admission and returned one per sdp_e2mcif_rd_cdt_lat_fifo_pop pulse from the ERDMA egress.
- Also provides a one-entry output pipe register and a stall performance counter.

Parameters:
- LAT_FIFO_DEPTH, 160: response latency FIFO depth in atoms; credit counter reset value and ceiling.
- CW, 9: credit counter width; must satisfy 2^CW > LAT_FIFO_DEPTH.

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- in_req_valid  in  1  request valid from ERDMA ingress
- in_req_ready  out  1  request accepted
- in_req_pd  in  79  [63:0] byte address, [78:64] size in atoms minus 1
- out_req_valid  out  1  request valid to MCIF
- out_req_ready  in  1  MCIF accepts
- out_req_pd  out  79  registered copy of in_req_pd
- cdt_lat_fifo_pop  in  1  one-atom credit return pulse
- op_load  in  1  layer start; clears stall counter
- perf_en  in  1  enables stall counting
- stall_cnt  out  32  cycles with in_req_valid & !in_req_ready while perf_en
- credit_cnt  out  CW  current free credits
- cdt_err  out  1  sticky error flag

Behaviour:
- Reset values:
  - credit_cnt = LAT_FIFO_DEPTH
  - out_req_valid = 0
  - out_req_pd = 0
  - stall_cnt = 0
  - cdt_err = 0
- need = in_req_pd[78:64] + 1, computed at 16 bits.
- eligible = need <= credit_cnt.
- in_req_ready = eligible & (!out_req_valid | out_req_ready). Ready depends on pd; this is intended. Ingress holds pd stable while valid.
- Accept = in_req_valid & in_req_ready. On accept, out_req_pd loads in_req_pd and out_req_valid = 1 next cycle (latency 1). Throughput is 1 request/cycle when MCIF is always ready.
- out_req_valid clears when out_req_ready & !accept. While valid & !ready, pd is held stable.
- Credit update per cycle: credit_next = credit_cnt - (accept ? need : 0) + (cdt_lat_fifo_pop ? 1 : 0).
  - Accept and pop in the same cycle: both applied.
  - A returned credit affects eligibility only from the next cycle; there is no combinational pop-to-ready path.
- Credit overflow: if credit_next > LAT_FIFO_DEPTH, credit_cnt saturates at LAT_FIFO_DEPTH and cdt_err is set.
- Oversize request: if in_req_valid & need > LAT_FIFO_DEPTH, cdt_err is set. Such a request is never accepted; the block stalls until reset.
- cdt_err is sticky until reset.
- stall_cnt:
  - Increments when perf_en & in_req_valid & !in_req_ready; saturates at 0xFFFFFFFF.
  - op_load clears it to 0; op_load has priority over increment in the same cycle.
- Credits are not reset by op_load; in-flight responses span layer boundaries.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any pending output request is dropped.
- No internal FSM beyond the pipe valid bit. Legal states: EMPTY (out_req_valid=0) and FULL (out_req_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept & out_req_ready.
  - FULL -> EMPTY on out_req_ready & !accept.

Test Plan:
- Reset, then in_req_valid with size=3 (need 4), out_req_ready=1 -> accepted in cycle 0; out_req_valid in cycle 1 with identical pd; credit_cnt=156.
- Drain to credit_cnt=2, present size=3 -> in_req_ready=0. Pulse cdt_lat_fifo_pop twice -> ready rises the cycle after the second pop and the request is accepted; credit_cnt=0.
- With credit_cnt=10, accept size=4 and pop in the same cycle -> credit_cnt=6 next cycle.
- Hold out_req_ready=0 for 5 cycles with the pipe full and a second request pending -> out_req_pd stable, in_req_ready=0; with perf_en=1, stall_cnt increments by 5. Assert op_load -> stall_cnt=0.
- At credit_cnt=160, pulse cdt_lat_fifo_pop -> credit_cnt stays 160 and cdt_err=1; cdt_err persists until rstn is asserted.
- Back-to-back size=0 requests with out_req_ready=1 for 20 cycles -> 20 accepts with no bubbles; credit_cnt=140 with no pops.
